// File: rtl/mem_align_pkg.sv
// rtl/mem_align_pkg.sv - size encodings, FSM states and size helper for the access aligner
package mem_align_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE0 = 2'd1,
    ST_ISSUE1 = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Encoding 2'b11 is handled as a full word.
  function automatic logic [2:0] size_nbytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lane_shifter.sv
// rtl/lane_shifter.sv - combinational byte-lane placement for stores and extraction for loads
module lane_shifter
  import mem_align_pkg::*;
(
  input  logic [1:0]  wr_off_i,
  input  logic [1:0]  wr_size_i,
  input  logic [31:0] wr_data_i,
  output logic [63:0] wr_data64_o,
  output logic [7:0]  wr_strb8_o,
  input  logic [1:0]  rd_off_i,
  input  logic [1:0]  rd_size_i,
  input  logic        rd_signed_i,
  input  logic [31:0] rd_lo_i,
  input  logic [23:0] rd_hi_i,
  output logic [31:0] rd_data_o
);

  logic [7:0]  wr_mask;
  logic [31:0] rd_word;

  // Store path: place right-justified data and its byte mask at the lane offset;
  // the upper half of each result belongs to the second word of a split access.
  always_comb begin
    wr_mask = 8'h0f;
    case (wr_size_i)
      SZ_BYTE: wr_mask = 8'h01;
      SZ_HALF: wr_mask = 8'h03;
      default: wr_mask = 8'h0f;
    endcase
    wr_strb8_o  = wr_mask << wr_off_i;
    wr_data64_o = {32'h0, wr_data_i} << {wr_off_i, 3'b000};
  end

  // Load path: the top byte of the high word can never reach the result
  // (at most bytes 3..6 of {hi,lo} are needed), so only 24 bits come in.
  always_comb begin
    rd_word = rd_lo_i;
    case (rd_off_i)
      2'd0: rd_word = rd_lo_i;
      2'd1: rd_word = {rd_hi_i[7:0],  rd_lo_i[31:8]};
      2'd2: rd_word = {rd_hi_i[15:0], rd_lo_i[31:16]};
      2'd3: rd_word = {rd_hi_i[23:0], rd_lo_i[31:24]};
      default: rd_word = rd_lo_i;
    endcase
  end

  // Truncate to the access size and extend.
  always_comb begin
    rd_data_o = rd_word;
    case (rd_size_i)
      SZ_BYTE: rd_data_o = {{24{rd_signed_i & rd_word[7]}},  rd_word[7:0]};
      SZ_HALF: rd_data_o = {{16{rd_signed_i & rd_word[15]}}, rd_word[15:0]};
      default: rd_data_o = rd_word;
    endcase
  end

endmodule

// File: rtl/mem_access_aligner.sv
// rtl/mem_access_aligner.sv - byte-addressed access aligner onto a word-organised synchronous RAM
module mem_access_aligner
  import mem_align_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              stall,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_widx,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int WIDX_W = ADDR_W - 2;
  localparam logic [WIDX_W-1:0] WIDX_ONE = {{(WIDX_W-1){1'b0}}, 1'b1};

  state_e              state_q;
  logic                write_q;
  logic                signed_q;
  logic                split_q;
  logic [1:0]          size_q;
  logic [1:0]          off_q;
  logic [WIDX_W-1:0]   widx_q;
  logic [31:0]         data_hi_q;
  logic [3:0]          strb_hi_q;
  logic [31:0]         lo_q;

  logic                mem_en_q;
  logic                mem_we_q;
  logic [WIDX_W-1:0]   mem_widx_q;
  logic [3:0]          mem_wstrb_q;
  logic [31:0]         mem_wdata_q;
  logic                resp_valid_q;
  logic [31:0]         resp_rdata_q;

  logic                split_d;
  logic [63:0]         wr_data64;
  logic [7:0]          wr_strb8;
  logic [31:0]         rd_lo;
  logic [23:0]         rd_hi;
  logic [31:0]         resp_rdata_d;

  // An access crosses a word boundary when its last byte lands past lane 3.
  always_comb begin
    split_d = ({1'b0, req_addr[1:0]} + size_nbytes(req_size)) > 3'd4;
  end

  // In RESP the RAM output is the high word of a split pair or the only word.
  always_comb begin
    rd_lo = split_q ? lo_q : mem_rdata;
    rd_hi = split_q ? mem_rdata[23:0] : 24'h0;
  end

  // Store placement works on the live request so ISSUE0 can be driven from
  // registers on the accept edge; load extraction works on latched fields.
  lane_shifter u_lane_shifter (
    .wr_off_i    (req_addr[1:0]),
    .wr_size_i   (req_size),
    .wr_data_i   (req_wdata),
    .wr_data64_o (wr_data64),
    .wr_strb8_o  (wr_strb8),
    .rd_off_i    (off_q),
    .rd_size_i   (size_q),
    .rd_signed_i (signed_q),
    .rd_lo_i     (rd_lo),
    .rd_hi_i     (rd_hi),
    .rd_data_o   (resp_rdata_d)
  );

  // Access sequencer: every memory-side and response output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      write_q      <= 1'b0;
      signed_q     <= 1'b0;
      split_q      <= 1'b0;
      size_q       <= SZ_BYTE;
      off_q        <= 2'd0;
      widx_q       <= '0;
      data_hi_q    <= 32'h0;
      strb_hi_q    <= 4'h0;
      lo_q         <= 32'h0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_widx_q   <= '0;
      mem_wstrb_q  <= 4'h0;
      mem_wdata_q  <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            write_q     <= req_write;
            signed_q    <= req_signed;
            split_q     <= split_d;
            size_q      <= req_size;
            off_q       <= req_addr[1:0];
            widx_q      <= req_addr[ADDR_W-1:2];
            data_hi_q   <= wr_data64[63:32];
            strb_hi_q   <= wr_strb8[7:4];
            mem_en_q    <= 1'b1;
            mem_we_q    <= req_write;
            mem_widx_q  <= req_addr[ADDR_W-1:2];
            mem_wstrb_q <= req_write ? wr_strb8[3:0] : 4'h0;
            mem_wdata_q <= wr_data64[31:0];
            state_q     <= ST_ISSUE0;
          end
        end
        ST_ISSUE0: begin
          if (split_q) begin
            mem_widx_q  <= widx_q + WIDX_ONE;
            mem_wstrb_q <= write_q ? strb_hi_q : 4'h0;
            mem_wdata_q <= data_hi_q;
            state_q     <= ST_ISSUE1;
          end else begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wstrb_q <= 4'h0;
            state_q     <= ST_RESP;
          end
        end
        ST_ISSUE1: begin
          lo_q        <= mem_rdata;
          mem_en_q    <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_wstrb_q <= 4'h0;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= write_q ? 32'h0 : resp_rdata_d;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign stall      = req_valid && !req_ready;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_widx   = mem_widx_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_aligner.sv
// tb/tb_mem_access_aligner.sv - randomized self-checking bench for mem_access_aligner
module tb_mem_access_aligner;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [29:0] mem_widx;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        preload;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] ram [logic [29:0]];
  logic [7:0]  ref_mem [logic [31:0]];

  mem_access_aligner #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .stall      (stall),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_widx   (mem_widx),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ram_rd(input logic [29:0] k);
    return ram.exists(k) ? ram[k] : 32'h0;
  endfunction

  // Word RAM with one-cycle read latency, read-before-write, per-lane strobes.
  always @(posedge clk) begin : ram_model
    logic [31:0] w;
    if (preload) begin
      ram[30'h100] = 32'h44332211;
      ram[30'h101] = 32'h88776655;
    end else if (mem_en) begin
      w = ram_rd(mem_widx);
      mem_rdata <= w;
      if (mem_we) begin
        for (int i = 0; i < 4; i++)
          if (mem_wstrb[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
        ram[mem_widx] = w;
      end
    end
  end

  // Reference: a flat little-endian byte memory, addresses wrap at 2^32.
  function automatic int nb_of(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    logic [31:0] v;
    int n;
    n = nb_of(sz);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_byte(a + 32'(i))) << (8 * i));
    if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    for (int i = 0; i < nb_of(sz); i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
  endtask

  // One access from accept to response; records the issue cycles and what was driven.
  task automatic access(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat, output int en_mask,
                        output logic [29:0] wi0, output logic [29:0] wi1,
                        output logic [3:0] st0, output logic [3:0] st1,
                        output logic [31:0] dt0, output logic [31:0] dt1);
    int nis;
    rd = 32'h0; lat = 0; en_mask = 0; nis = 0;
    wi0 = '0; wi1 = '0; st0 = '0; st1 = '0; dt0 = '0; dt1 = '0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(negedge clk);
    chk("accept_ready", 32'(req_ready), 32'd1);
    chk("resp_pulse_once", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (mem_en) begin
        en_mask = en_mask | (1 << k);
        if (nis == 0) begin wi0 = mem_widx; st0 = mem_wstrb; dt0 = mem_wdata; end
        else          begin wi1 = mem_widx; st1 = mem_wstrb; dt1 = mem_wdata; end
        nis++;
      end
      if (!mem_en || !w) chk("wstrb_zero", 32'(mem_wstrb), 32'd0);
      if (resp_valid) begin
        lat = k;
        rd = resp_rdata;
      end
    end
  endtask

  task automatic run_check(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd,
                           output logic [29:0] wi0, output logic [29:0] wi1,
                           output logic [3:0] st0, output logic [3:0] st1,
                           output logic [31:0] dt0, output logic [31:0] dt1);
    int lat, en_mask;
    bit split;
    logic [31:0] exp_rd;
    split = (int'(a[1:0]) + nb_of(sz)) > 4;
    exp_rd = w ? 32'h0 : ref_load(a, sz, sg);
    access(w, sz, sg, a, wd, rd, lat, en_mask, wi0, wi1, st0, st1, dt0, dt1);
    if (w) ref_store(a, sz, wd);
    chk("rdata", rd, exp_rd);
    chk("latency", 32'(lat), split ? 32'd4 : 32'd3);
    chk("en_cycles", 32'(en_mask), split ? 32'b110 : 32'b010);
    chk("widx0", 32'(wi0), 32'(a[31:2]));
    if (split) chk("widx1", 32'(wi1), 32'(30'(a[31:2] + 30'd1)));
  endtask

  logic [31:0] rd, dt0, dt1, exp_b;
  logic [29:0] wi0, wi1;
  logic [3:0]  st0, st1;
  int          lat, seen;

  initial begin
    rst = 1'b1; preload = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 8; i++) ref_mem[32'h400 + 32'(i)] = 8'(8'h11 * (i + 1));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_widx", 32'(mem_widx), 32'd0);
    chk("rst_wdata", mem_wdata, 32'h0);
    preload = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // Signed byte in the top lane.
    run_check(1'b0, 2'd0, 1'b1, 32'h407, 32'h0, rd, wi0, wi1, st0, st1, dt0, dt1);
    chk("tp_sbyte", rd, 32'hFFFFFF88);
    chk("tp_sbyte_widx", 32'(wi0), 32'h101);

    // Misaligned word load spanning two words.
    run_check(1'b0, 2'd2, 1'b0, 32'h402, 32'h0, rd, wi0, wi1, st0, st1, dt0, dt1);
    chk("tp_word_split", rd, 32'h66554433);

    // Misaligned half store, then read both words back.
    run_check(1'b1, 2'd1, 1'b0, 32'h403, 32'h0000BEEF, rd, wi0, wi1, st0, st1, dt0, dt1);
    chk("tp_hst_widx0", 32'(wi0), 32'h100);
    chk("tp_hst_strb0", 32'(st0), 32'b1000);
    chk("tp_hst_data0", 32'(dt0[31:24]), 32'hEF);
    chk("tp_hst_widx1", 32'(wi1), 32'h101);
    chk("tp_hst_strb1", 32'(st1), 32'b0001);
    chk("tp_hst_data1", 32'(dt1[7:0]), 32'hBE);
    run_check(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, rd, wi0, wi1, st0, st1, dt0, dt1);
    chk("tp_rb_lo", rd, 32'hEF332211);
    run_check(1'b0, 2'd2, 1'b0, 32'h404, 32'h0, rd, wi0, wi1, st0, st1, dt0, dt1);
    chk("tp_rb_hi", rd, 32'h887766BE);

    // Word index wrap at the top of the address space.
    run_check(1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0, rd, wi0, wi1, st0, st1, dt0, dt1);
    chk("tp_wrap_widx0", 32'(wi0), 32'h3FFFFFFF);
    chk("tp_wrap_widx1", 32'(wi1), 32'h0);

    // Reset while the second word of a split load is being issued.
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h402; req_wdata = 32'h0;
    @(negedge clk);
    chk("rst_mid_accept", 32'(req_ready), 32'd1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_issue0", 32'(mem_en), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_issue1", 32'(mem_widx), 32'h101);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_en", 32'(mem_en), 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("rst_no_resp", 32'(seen), 32'd0);
    run_check(1'b0, 2'd1, 1'b0, 32'h400, 32'h0, rd, wi0, wi1, st0, st1, dt0, dt1);
    chk("tp_after_rst", rd, 32'h00002211);

    // Back-to-back: second request held valid until the response cycle.
    exp_b = ref_load(32'h405, 2'd2, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h401; req_wdata = 32'h0;
    @(negedge clk);
    chk("b2b_accept_a", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_size = 2'd2; req_signed = 1'b1; req_addr = 32'h405;
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = k;
        chk("b2b_rdata_a", resp_rdata, 32'h22);
        chk("b2b_ready_on_resp", 32'(req_ready), 32'd1);
        chk("b2b_stall_on_resp", 32'(stall), 32'd0);
      end else begin
        chk("b2b_stall", 32'(stall), 32'd1);
      end
    end
    chk("b2b_lat_a", 32'(lat), 32'd3);
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = k;
        chk("b2b_rdata_b", resp_rdata, exp_b);
      end
    end
    chk("b2b_lat_b", 32'(lat), 32'd4);

    // Randomized mix of loads and stores near 0x400 and around the wrap point.
    for (int n = 0; n < 80; n++) begin
      logic        w, sg;
      logic [1:0]  sz;
      logic [31:0] a, wd;
      w  = 1'($urandom);
      sg = 1'($urandom);
      sz = 2'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 15))
                                        : 32'h400 + 32'($urandom_range(0, 31));
      wd = $urandom;
      run_check(w, sz, sg, a, wd, rd, wi0, wi1, st0, st1, dt0, dt1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_access_aligner.md
# mem_access_aligner

Byte-to-word access aligner between the MEM stage and the word-organised data memory. It accepts byte-addressed load/store requests and converts each byte address to a word index (address >> 2), the inverse of the word-to-byte offset scaling used in branch-target generation. It drives byte-lane strobes, and splits misaligned half/word accesses into two sequential word accesses. Loaded data is returned aligned and sign/zero-extended, with a stall to the pipeline while busy.

## Interface
- ADDR_W, 32, byte-address width; word index width is ADDR_W-2
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  MEM-stage access request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- req_signed  in  1  sign-extend load result (ignored for stores/word)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- req_ready  out  1  high only in IDLE
- stall  out  1  req_valid && !req_ready
- resp_valid  out  1  one-cycle pulse, access complete (loads and stores)
- resp_rdata  out  32  aligned/extended load data; 0 for stores
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_widx  out  ADDR_W-2  word index
- mem_wstrb  out  4  byte-lane write strobes, lane i = bits [8i+7:8i]
- mem_wdata  out  32  lane-positioned write data
- mem_rdata  in  32  read data, valid the cycle after mem_en (synchronous RAM)

## Operation
- Little-endian lanes. off = addr[1:0], nbytes = 1/2/4. split = (off + nbytes > 4).
- Accepted request: req_valid && req_ready. All request fields are latched.
- FSM states:
  - IDLE → ISSUE0 on accept.
  - ISSUE0 → ISSUE1 if split, else RESP.
  - ISSUE1 → RESP.
  - RESP → IDLE.
- ISSUE0:
  - mem_en=1, mem_we=write, mem_widx=addr>>2.
  - Strobes from the 8-bit mask ((1<<nbytes)-1)<<off, using the low 4 bits.
  - Data from the 64-bit value (wdata<<(8*off)), using the low 32 bits.
- ISSUE1:
  - mem_widx = (addr>>2)+1, modulo 2^(ADDR_W-2). Wraps to 0.
  - Strobes and data come from the upper 4 and upper 32 bits.
  - mem_rdata is captured as lo word.
- RESP:
  - mem_rdata is taken as the hi word (split) or the only word (non-split; then lo=mem_rdata, hi=0).
  - Result = {hi,lo} >> (8*off), truncated to nbytes, then extended per req_signed.
  - resp_valid and resp_rdata are registered at the end of RESP.
- Outside ISSUE0/ISSUE1: mem_en=0, mem_we=0, mem_wstrb=0. mem_widx and mem_wdata hold their last values.
- For loads, mem_wstrb=0 in every state.

## Timing
- Accept at cycle T.
- Aligned access: ISSUE0 at T+1, RESP at T+2, resp_valid at T+3.
- Split access: ISSUE0 at T+1, ISSUE1 at T+2, RESP at T+3, resp_valid at T+4.
- resp_valid is high for exactly one cycle. That cycle is IDLE, so a new request can be accepted in the same cycle (back-to-back throughput: 3 or 4 cycles per access).
- resp_rdata holds its value until the next resp_valid.
- req_* inputs are sampled only on accept; changes while busy are ignored.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, mem_en=0, mem_we=0, mem_wstrb=0, mem_widx=0, mem_wdata=0.
- Reset mid-operation (any state): the FSM returns to IDLE the next cycle.
  - The in-flight access is abandoned with no resp_valid.
  - A write already issued in ISSUE0 is not undone.

## Structure
- Package mem_align_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum, and an nbytes-from-size function.
- Sub-module lane_shifter: purely combinational.
  - Write path: 64-bit data and 8-bit strobe placement.
  - Read path: {hi,lo} extract plus sign/zero extension.
- The FSM and registers live in the top module.

## Test plan
- Memory preload: widx 0x100=0x44332211, widx 0x101=0x88776655 (byte addr 0x400).
- Signed byte load at 0x407 → mem_widx 0x101 at T+1 only; resp_rdata=0xFFFFFF88 at T+3.
- Word load at 0x402 → mem_widx 0x100 at T+1, then 0x101 at T+2; resp_rdata=0x66554433 at T+4.
- Half store 0xBEEF at 0x403:
  - T+1: widx 0x100, wstrb 1000, wdata[31:24]=0xEF.
  - T+2: widx 0x101, wstrb 0001, wdata[7:0]=0xBE.
  - Read-back of both words = 0xEF332211 and 0x887766BE.
- Word load at byte addr 0xFFFFFFFE → mem_widx 0x3FFFFFFF, then 0x00000000 (wrap); split latency 4.
- rst asserted during ISSUE1 → mem_en=0 and req_ready=1 the next cycle, no resp_valid ever. A following aligned unsigned half load at 0x400 returns 0x00002211.
- Back-to-back: new request held valid on the resp_valid cycle → accepted that cycle; stall=1 during every busy cycle.
